// File: rtl/light_sequencer_pkg.sv
// Shared keyboard definitions: the twelve note key codes, the note-player
// state encoding and small sizing helpers used by the light and tone blocks.
package light_sequencer_pkg;

  localparam logic [7:0] KEY_Z = 8'h7A;
  localparam logic [7:0] KEY_S = 8'h73;
  localparam logic [7:0] KEY_X = 8'h78;
  localparam logic [7:0] KEY_D = 8'h64;
  localparam logic [7:0] KEY_C = 8'h63;
  localparam logic [7:0] KEY_V = 8'h76;
  localparam logic [7:0] KEY_G = 8'h67;
  localparam logic [7:0] KEY_B = 8'h62;
  localparam logic [7:0] KEY_H = 8'h68;
  localparam logic [7:0] KEY_N = 8'h6E;
  localparam logic [7:0] KEY_J = 8'h6A;
  localparam logic [7:0] KEY_M = 8'h6D;

  localparam logic [7:0] NO_NOTE = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_t;

  function automatic logic is_note_code(input logic [7:0] code);
    case (code)
      KEY_Z, KEY_S, KEY_X, KEY_D, KEY_C, KEY_V,
      KEY_G, KEY_B, KEY_H, KEY_N, KEY_J, KEY_M: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // Bits needed to hold the larger of the two cycle counts without wrapping.
  function automatic int timer_width(input longint unsigned hold,
                                     input longint unsigned gap);
    longint unsigned biggest;
    int w;
    biggest = (hold > gap) ? hold : gap;
    w = $clog2(biggest + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Small synchronous FIFO for queued note codes; head word is visible
// combinationally so the player can load it on the same edge it pops.
module note_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear && !rst) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/light_sequencer.sv
// Queues note keys from the keyboard receiver and presents each one on
// outSel for a fixed hold time, separated by a fixed silent gap.
module light_sequencer
  import light_sequencer_pkg::*;
#(
  parameter longint unsigned HOLD_CYCLES = 10000000,
  parameter longint unsigned GAP_CYCLES  = 1000000,
  parameter int              FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inKey,
  input  logic       inValid,
  output logic       outReady,
  input  logic       inClear,
  output logic [7:0] outSel,
  output logic       outBusy,
  output logic       outDrop
);

  localparam int              TW        = timer_width(HOLD_CYCLES, GAP_CYCLES);
  localparam bit              HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [TW-1:0]   HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]   GAP_LOAD  = HAS_GAP ? TW'(GAP_CYCLES - 1) : '0;

  seq_state_t    state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [7:0]    sel_reg, sel_next;
  logic [7:0]    out_sel_reg;
  logic          drop_reg;

  logic          accept;
  logic          key_is_note;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;

  assign key_is_note = is_note_code(inKey);
  assign accept      = inValid && outReady;
  assign outReady    = !fifo_full;

  note_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (inClear),
    .push      (accept && key_is_note),
    .push_data (inKey),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    sel_next   = sel_reg;
    fifo_pop   = 1'b0;
    if (inClear) begin
      state_next = ST_IDLE;
      timer_next = '0;
      sel_next   = NO_NOTE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          sel_next = NO_NOTE;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            sel_next   = fifo_head;
            timer_next = HOLD_LOAD;
            state_next = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (timer_reg == '0) begin
            sel_next = NO_NOTE;
            if (HAS_GAP) begin
              timer_next = GAP_LOAD;
              state_next = ST_GAP;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            timer_next = timer_reg - TW'(1);
          end
        end
        ST_GAP: begin
          sel_next = NO_NOTE;
          if (timer_reg == '0) begin
            state_next = ST_IDLE;
          end else begin
            timer_next = timer_reg - TW'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          timer_next = '0;
          sel_next   = NO_NOTE;
        end
      endcase
    end
  end

  // outSel is a second register stage behind sel_reg so the LED/tone inputs
  // see the code two edges after the key was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= '0;
      sel_reg     <= NO_NOTE;
      out_sel_reg <= NO_NOTE;
      drop_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      sel_reg     <= sel_next;
      out_sel_reg <= inClear ? NO_NOTE : sel_reg;
      drop_reg    <= accept && !key_is_note && !inClear;
    end
  end

  assign outSel  = out_sel_reg;
  assign outDrop = drop_reg;
  assign outBusy = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with HOLD=4, GAP=2, DEPTH=4.
module tb_light_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] inKey = 8'h00;
  logic       inValid = 1'b0;
  logic       outReady;
  logic       inClear = 1'b0;
  logic [7:0] outSel;
  logic       outBusy;
  logic       outDrop;

  int n_cmp = 0;
  int n_err = 0;

  light_sequencer #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .inKey    (inKey),
    .inValid  (inValid),
    .outReady (outReady),
    .inClear  (inClear),
    .outSel   (outSel),
    .outBusy  (outBusy),
    .outDrop  (outDrop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_key(input logic [7:0] k);
    inKey   = k;
    inValid = 1'b1;
    $display("push key=%02h ready=%0b", k, outReady);
    tick();
    inValid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c;
    c = 0;
    while (outBusy !== 1'b0 && c < budget) begin
      tick();
      c++;
    end
    chk(tag, outBusy, 1'b0);
  endtask

  logic [7:0] exp_trace [21];
  logic [7:0] keys6 [6];
  logic [7:0] seen [$];
  logic [7:0] prev_sel;
  logic       acc;
  int         idx;
  int         cyc;
  int         first_full_idx;

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", outReady, 1'b1);
    chk("rst_sel",   outSel,   8'h00);
    chk("rst_busy",  outBusy,  1'b0);
    chk("rst_drop",  outDrop,  1'b0);

    // Single note: latency, hold length, gap, busy release
    push_key(8'h7A);
    chk("single_e0_sel",  outSel,  8'h00);
    chk("single_e0_busy", outBusy, 1'b1);
    tick();
    chk("single_e1_sel", outSel, 8'h00);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk($sformatf("single_e%0d_sel", i), outSel, 8'h7A);
    end
    tick();
    chk("single_e6_sel",  outSel,  8'h00);
    chk("single_e6_busy", outBusy, 1'b1);
    tick();
    chk("single_e7_busy", outBusy, 1'b0);

    // Three back-to-back notes: 4 cycles each, 3 zero cycles between
    exp_trace = '{8'h00, 8'h00, 8'h7A, 8'h7A, 8'h7A, 8'h7A, 8'h00, 8'h00, 8'h00,
                  8'h78, 8'h78, 8'h78, 8'h78, 8'h00, 8'h00, 8'h00,
                  8'h63, 8'h63, 8'h63, 8'h63, 8'h00};
    push_key(8'h7A);
    chk("b2b_e0", outSel, exp_trace[0]);
    push_key(8'h78);
    chk("b2b_e1", outSel, exp_trace[1]);
    push_key(8'h63);
    chk("b2b_e2", outSel, exp_trace[2]);
    for (int k = 3; k < 21; k++) begin
      tick();
      chk($sformatf("b2b_e%0d", k), outSel, exp_trace[k]);
    end
    wait_idle("b2b_idle", 20);

    // Six notes with inValid held: backpressure, order, repeated codes kept
    keys6 = '{8'h7A, 8'h73, 8'h73, 8'h64, 8'h63, 8'h76};
    idx = 0;
    cyc = 0;
    first_full_idx = -1;
    prev_sel = 8'h00;
    inKey   = keys6[0];
    inValid = 1'b1;
    while ((idx < 6 || outBusy) && cyc < 300) begin
      acc = inValid && outReady;
      if (inValid && !outReady && first_full_idx < 0) first_full_idx = idx;
      tick();
      cyc++;
      if (acc) begin
        $display("accepted key=%02h idx=%0d", keys6[idx], idx);
        idx++;
        if (idx < 6) inKey = keys6[idx];
        else inValid = 1'b0;
      end
      if (outSel != 8'h00 && prev_sel == 8'h00) seen.push_back(outSel);
      prev_sel = outSel;
    end
    inValid = 1'b0;
    chk("burst_timeout",   (cyc < 300), 1'b1);
    chk("burst_full_at",   first_full_idx, 5);
    chk("burst_accepted",  idx, 6);
    chk("burst_presented", seen.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("burst_note%0d", i), (i < seen.size()) ? seen[i] : 8'hFF, keys6[i]);
    end

    // Non-note key is dropped with a one-cycle pulse
    push_key(8'h41);
    chk("drop_pulse", outDrop,  1'b1);
    chk("drop_sel",   outSel,   8'h00);
    chk("drop_busy",  outBusy,  1'b0);
    chk("drop_ready", outReady, 1'b1);
    tick();
    chk("drop_end",   outDrop,  1'b0);
    tick();
    chk("drop_nosel", outSel,   8'h00);

    // Clear mid-HOLD with two queued and a concurrent push
    push_key(8'h7A);
    push_key(8'h78);
    push_key(8'h63);
    chk("clr_pre_sel", outSel, 8'h7A);
    inClear = 1'b1;
    inKey   = 8'h6D;
    inValid = 1'b1;
    $display("clear with push key=%02h", inKey);
    tick();
    inClear = 1'b0;
    inValid = 1'b0;
    chk("clr_sel",   outSel,   8'h00);
    chk("clr_busy",  outBusy,  1'b0);
    chk("clr_drop",  outDrop,  1'b0);
    chk("clr_ready", outReady, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("clr_quiet%0d", i), {outSel, outBusy}, 9'h000);
    end
    inClear = 1'b1;
    inKey   = 8'h41;
    inValid = 1'b1;
    $display("clear with push key=%02h", inKey);
    tick();
    inClear = 1'b0;
    inValid = 1'b0;
    chk("clr_nodrop", outDrop, 1'b0);

    // Reset mid-GAP with a note still queued, then normal play
    push_key(8'h7A);
    push_key(8'h78);
    repeat (4) tick();
    chk("rstgap_pre_busy", outBusy, 1'b1);
    rst = 1'b1;
    $display("reset asserted mid-gap");
    tick();
    rst = 1'b0;
    chk("rstgap_sel",   outSel,   8'h00);
    chk("rstgap_busy",  outBusy,  1'b0);
    chk("rstgap_drop",  outDrop,  1'b0);
    chk("rstgap_ready", outReady, 1'b1);
    tick();
    chk("rstgap_quiet", {outSel, outBusy}, 9'h000);
    push_key(8'h63);
    tick();
    chk("post_e1_sel", outSel, 8'h00);
    tick();
    chk("post_e2_sel", outSel, 8'h63);
    wait_idle("post_idle", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
